// File: rtl/alu8_pkg.sv
// Shared types and constants for the 8-bit ALU command sequencer.
package alu8_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int RES_W  = 16;

  localparam logic [OP_W-1:0] ADD  = 3'd0;
  localparam logic [OP_W-1:0] SUB  = 3'd1;
  localparam logic [OP_W-1:0] MUL  = 3'd2;
  localparam logic [OP_W-1:0] AND  = 3'd3;
  localparam logic [OP_W-1:0] OR   = 3'd4;
  localparam logic [OP_W-1:0] NAND = 3'd5;
  localparam logic [OP_W-1:0] NOR  = 3'd6;
  localparam logic [OP_W-1:0] XOR  = 3'd7;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu8_cmd_fifo.sv
// Synchronous command FIFO; ready is a registered copy of "not full" held low during reset.
module alu8_cmd_fifo
  import alu8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  cmd_t                   wr_data,
  input  logic                   pop,
  output cmd_t                   rd_data,
  output logic                   empty,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          full, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign ready   = ready_q;
  assign count   = count_q;

endmodule

// File: rtl/alu8_cmd_sequencer.sv
// Drives queued commands into the combinational ALU, waits SETTLE cycles, returns results in order.
// Optional feature macro: ALU8_OP_COUNT_EN adds a 16-bit response handshake counter (op_count).
module alu8_cmd_sequencer
  import alu8_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_operation,
  output logic [DATA_W-1:0] alu_operand_A,
  output logic [DATA_W-1:0] alu_operand_B,
  input  logic [RES_W-1:0]  alu_result,
  input  logic              alu_carry_flag,
  input  logic              alu_zero_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OP_W-1:0]   rsp_op,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
`ifdef ALU8_OP_COUNT_EN
  output logic [15:0]       op_count,
`endif
  output logic              busy
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  cmd_t                   fifo_head;
  logic                   fifo_pop, fifo_empty, fifo_ready;
  logic [$clog2(DEPTH):0] fifo_count;

  seq_state_t        state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OP_W-1:0]   rsp_op_q, rsp_op_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d;

  alu8_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid && fifo_ready),
    .wr_data ({cmd_op, cmd_a, cmd_b}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .ready   (fifo_ready),
    .count   (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_op_d     = rsp_op_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_zero_d   = rsp_zero_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == '0) begin
          rsp_valid_d  = 1'b1;
          rsp_op_d     = alu_op_q;
          rsp_result_d = alu_result;
          // The ALU does not refresh carry for non-arithmetic ops, so mask the stale value.
          rsp_carry_d  = (alu_op_q == ADD || alu_op_q == SUB) ? alu_carry_flag : 1'b0;
          rsp_zero_d   = alu_zero_flag;
          state_d      = RESP;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_pop) begin
      alu_op_d = fifo_head.op;
      alu_a_d  = fifo_head.a;
      alu_b_d  = fifo_head.b;
      settle_d = SW'(SETTLE - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

`ifdef ALU8_OP_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (state_q == RESP && rsp_ready) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

  assign cmd_ready     = fifo_ready;
  assign alu_operation = alu_op_q;
  assign alu_operand_A = alu_a_q;
  assign alu_operand_B = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_op        = rsp_op_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_carry     = rsp_carry_q;
  assign rsp_zero      = rsp_zero_q;
  assign busy          = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_alu8_cmd_sequencer.sv
// Bench for alu8_cmd_sequencer with a behavioural 8-bit ALU; define ALU8_OP_COUNT_EN to cover op_count.
module tb_alu8_cmd_sequencer;
  import alu8_pkg::*;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a, cmd_b;
  logic [OP_W-1:0]   alu_operation;
  logic [DATA_W-1:0] alu_operand_A, alu_operand_B;
  logic [RES_W-1:0]  alu_result;
  logic              alu_carry_flag, alu_zero_flag;
  logic              rsp_valid, rsp_ready;
  logic [OP_W-1:0]   rsp_op;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_carry, rsp_zero, busy;
`ifdef ALU8_OP_COUNT_EN
  logic [15:0]       op_count;
`endif

  alu8_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_operation(alu_operation), .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
    .alu_result(alu_result), .alu_carry_flag(alu_carry_flag), .alu_zero_flag(alu_zero_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
`ifdef ALU8_OP_COUNT_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {carry, result}; carry is meaningful only for ADD/SUB.
  function automatic logic [16:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb, r;
    logic        c;
    ea = {8'h00, a};
    eb = {8'h00, b};
    c  = 1'b0;
    case (op)
      ADD:     begin r = ea + eb; c = r[8]; end
      SUB:     begin r = ea - eb; c = (a < b); end
      MUL:     r = ea * eb;
      AND:     r = ea & eb;
      OR:      r = ea | eb;
      NAND:    r = ~(ea & eb);
      NOR:     r = ~(ea | eb);
      default: r = ea ^ eb;
    endcase
    return {c, r};
  endfunction

  logic [16:0] alu_cr;
  always_comb begin
    alu_cr         = alu_calc(alu_operation, alu_operand_A, alu_operand_B);
    alu_result     = alu_cr[15:0];
    alu_zero_flag  = (alu_cr[15:0] == 16'h0000);
    // Stale carry on logic/MUL ops: leak operand bit so masking is exercised.
    alu_carry_flag = (alu_operation == ADD || alu_operation == SUB) ? alu_cr[16] : alu_operand_A[0];
  end

  typedef struct packed {
    logic [2:0]  op;
    logic        c;
    logic        z;
    logic [15:0] res;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic exp_t ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [16:0] cr;
    exp_t e;
    cr    = alu_calc(op, a, b);
    e.op  = op;
    e.res = cr[15:0];
    e.c   = (op == ADD || op == SUB) ? cr[16] : 1'b0;
    e.z   = (cr[15:0] == 16'h0000);
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Response monitor: each valid&ready seen at the falling edge is one handshake at the next rise.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", {11'b0, rsp_op, rsp_carry, rsp_zero, rsp_result}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("rsp", {11'b0, rsp_op, rsp_carry, rsp_zero, rsp_result}, {11'b0, e});
      end
      hs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    bit done;
    done = 1'b0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic offer(input int n, output int acc);
    int tries;
    acc = 0;
    tries = 0;
    while (acc < n && tries < n + 10) begin
      cmd_op = 3'(acc); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back(ref_rsp(cmd_op, cmd_a, cmd_b));
        acc++;
      end
      @(posedge clk); #1;
      tries++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, acc, vcount;
    vt[0]  = '{ADD,  8'd200, 8'd100, 16'd300,  1'b1, 1'b0};
    vt[1]  = '{SUB,  8'd5,   8'd5,   16'h0000, 1'b0, 1'b1};
    vt[2]  = '{SUB,  8'd3,   8'd5,   16'hFFFE, 1'b1, 1'b0};
    vt[3]  = '{MUL,  8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0};
    vt[4]  = '{NAND, 8'hFF,  8'hFF,  16'hFF00, 1'b0, 1'b0};
    vt[5]  = '{AND,  8'hF1,  8'h3C,  16'h0030, 1'b0, 1'b0};
    vt[6]  = '{OR,   8'h00,  8'h00,  16'h0000, 1'b0, 1'b1};
    vt[7]  = '{XOR,  8'hAB,  8'h55,  16'h00FE, 1'b0, 1'b0};
    vt[8]  = '{NOR,  8'h0F,  8'hF0,  16'hFF00, 1'b0, 1'b0};
    vt[9]  = '{ADD,  8'd255, 8'd1,   16'h0100, 1'b1, 1'b0};
    vt[10] = '{ADD,  8'd0,   8'd0,   16'h0000, 1'b0, 1'b1};
    vt[11] = '{OR,   8'hA1,  8'h50,  16'h00F1, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu", {13'b0, alu_operation, alu_operand_A, alu_operand_B}, 32'd0);
    check("rst_rsp", {11'b0, rsp_op, rsp_carry, rsp_zero, rsp_result}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Single ADD: measure edges from acceptance to rsp_valid.
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    cmd_op = ADD; cmd_a = 8'd200; cmd_b = 8'd100; cmd_valid = 1'b1;
    @(negedge clk);
    if (cmd_ready) sb.push_back(exp_t'{ADD, 1'b1, 1'b0, 16'd300});
    check("lat_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (rsp_valid) break;
      @(posedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(SETTLE + 1));
    drain();
    check("alu_hold", {13'b0, alu_operation, alu_operand_A, alu_operand_B}, {13'b0, ADD, 8'd200, 8'd100});

    // Table vectors streamed back-to-back.
    for (int i = 0; i < 12; i++)
      send(vt[i].op, vt[i].a, vt[i].b, exp_t'{vt[i].op, vt[i].c, vt[i].z, vt[i].res});
    drain();
    check("alu_hold_last", {13'b0, alu_operation, alu_operand_A, alu_operand_B}, {13'b0, OR, 8'hA1, 8'h50});
    check("idle_busy", 32'(busy), 32'd0);

    // Backpressure: 6 offered with consumer stalled.
    rsp_ready = 1'b0;
    offer(6, acc);
    check("bp_accepted", 32'(acc), 32'd5);
    @(negedge clk);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    hs_cyc.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("bp_ready_back", 32'(cmd_ready), 32'd1);
    drain();
    check("bp_rsp_count", 32'(hs_cyc.size()), 32'd5);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("bp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(SETTLE + 1));

    // Reset while DRIVE holds a command and three more are queued.
    rsp_ready = 1'b0;
    offer(5, acc);
    check("rstmid_accepted", 32'(acc), 32'd5);
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rstmid_outs", {5'b0, alu_operation, alu_operand_A, alu_operand_B, rsp_op, rsp_carry, rsp_zero}, 32'd0);
    check("rstmid_result", 32'(rsp_result), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) vcount++;
    end
    check("rstmid_no_stale", 32'(vcount), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);

`ifdef ALU8_OP_COUNT_EN
    for (int i = 0; i < 3; i++) send(ADD, 8'(i), 8'd1, exp_t'{ADD, 1'b0, 1'b0, 16'(i + 1)});
    drain();
    check("op_count_3", 32'(op_count), 32'd3);
    @(posedge clk); #1;
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    @(negedge clk);
    check("op_count_preload", 32'(op_count), 32'h0000FFFF);
    @(posedge clk); #1;
    send(MUL, 8'd2, 8'd3, exp_t'{MUL, 1'b0, 1'b0, 16'd6});
    drain();
    check("op_count_wrap", 32'(op_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
